ccsds_cmprs_ctrl: RTL and testbench
===================================

CCSDS_CMPRS_CTRL -- requirements
Module: ccsds_cmprs_ctrl

Parameters
REQ-001 SHALL provide X_LEN, default 11, width of the X_max configuration field.
REQ-002 SHALL provide Z_LEN, default 8, width of the Z_max configuration field.
REQ-003 SHALL provide L_LEN, default 16, width of the line-count field.

Interface
REQ-004 sclk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that launches one frame; honoured only in IDLE.
REQ-007 abort  in  1  level; forces a return to IDLE.
REQ-008 cfg_x_max / cfg_z_max / cfg_mode / cfg_lines  in  X_LEN / Z_LEN / 2 / L_LEN  frame configuration, sampled on the start cycle.
REQ-009 src_valid  in  1 ; src_ready  out  1 ; src_data  in  24  source beat of two 12-bit samples {high,low}.
REQ-010 X_max / Z_max / mode  out  X_LEN / Z_LEN / 2  configuration presented to the compressor.
REQ-011 cfg_en  out  1  configuration strobe to the compressor.
REQ-012 cmprs_rdf_data_ready  in  1  compressor can accept a beat.
REQ-013 cmprs_rdf_data_valid  out  1 ; cmprs_rdf_rd_data  out  32 = {4'd0,high,4'd0,low} ; cmprs_rdf_data_end  out  1  last beat of the frame.
REQ-014 cmprs_dout_req  in  1 ; ddr_wr_rdy  in  1 ; cmprs_fifo_grant  out  1  grant of the DDR write port.
REQ-015 cmprs_dout_end  in  1  compressor has flushed its output.
REQ-016 busy  out  1 ; done  out  1  one-cycle pulse ; cfg_err  out  1  sticky.

Function
REQ-017 SHALL implement the FSM IDLE->CFG->WAIT->STREAM->DRAIN->DONE->IDLE.
REQ-018 IDLE: on start with cfg_lines!=0, SHALL latch the configuration and go to CFG.
REQ-019 IDLE: on start with cfg_lines==0, SHALL stay in IDLE and set cfg_err; cfg_err SHALL clear on the next valid start.
REQ-020 CFG: SHALL assert cfg_en for exactly 1 cycle, then go to WAIT.
REQ-021 X_max, Z_max and mode SHALL hold the latched values from CFG until the next accepted start.
REQ-022 WAIT: SHALL go to STREAM on the first cycle cmprs_rdf_data_ready=1.
REQ-023 Beats per line SHALL be (X_max+1)*(Z_max+1), computed at full width (X_LEN+Z_LEN bits) with no truncation.
REQ-024 Total beats SHALL be beats per line * cfg_lines.
REQ-025 STREAM: src_ready SHALL equal cmprs_rdf_data_ready while beats remain, and 0 otherwise (combinational).
REQ-026 A transfer SHALL occur when src_valid && src_ready.
REQ-027 Each transfer SHALL drive cmprs_rdf_data_valid=1 and cmprs_rdf_rd_data on the next cycle (latency 1, registered); otherwise valid=0.
REQ-028 The beat counter SHALL wrap to 0 at the end of each line while the line counter increments.
REQ-029 cmprs_rdf_data_end SHALL be 1 only together with the valid of the final beat of the final line; the FSM SHALL then go to DRAIN.
REQ-030 A src_valid=0 gap SHALL stall the transfer without error; no beat is lost or duplicated.
REQ-031 DRAIN: SHALL wait for cmprs_dout_end=1, then go to DONE.
REQ-032 A cmprs_dout_end seen in any state other than DRAIN SHALL be ignored.
REQ-033 DONE: SHALL assert done for 1 cycle, then return to IDLE.
REQ-034 busy SHALL be 1 in every state except IDLE.
REQ-035 Grant (independent of the FSM): cmprs_fifo_grant SHALL rise one cycle after cmprs_dout_req && ddr_wr_rdy.
REQ-036 cmprs_fifo_grant SHALL stay high while cmprs_dout_req=1 and fall one cycle after cmprs_dout_req=0; a ddr_wr_rdy drop during a grant SHALL NOT revoke it.
REQ-037 abort SHALL take priority over every transition: next cycle state=IDLE, counters=0, src_ready=0, all strobes=0, done not pulsed, grant cleared.
REQ-038 A start arriving in any state other than IDLE SHALL be ignored.

Reset
REQ-039 While rst=1 (asynchronous), the FSM SHALL be in IDLE and all counters SHALL be 0.
REQ-040 While rst=1, every output SHALL be 0: X_max, Z_max, mode, cfg_en, cmprs_rdf_data_valid, cmprs_rdf_rd_data, cmprs_rdf_data_end, cmprs_fifo_grant, src_ready, busy, done, cfg_err.
REQ-041 A reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait for a new start.

Verification
REQ-042 x_max=3, z_max=1, lines=2, src and ready always 1 -> cfg_en 1 cycle; 16 valid beats, data_end on beat 16 only; done 1 cycle after cmprs_dout_end.
REQ-043 Same configuration, src_valid toggling 1/0 and ready low 3 cycles mid-line -> exactly 16 beats with in-order data and no duplicates.
REQ-044 start with lines=0 -> cfg_err=1, busy stays 0; next start with lines=1 -> cfg_err clears and the frame runs.
REQ-045 abort at beat 5 -> IDLE next cycle with all outputs 0; new start -> beat count restarts at 0.
REQ-046 cmprs_dout_req=1 with ddr_wr_rdy=0 for 4 cycles, then 1 -> grant rises 1 cycle after; ddr_wr_rdy drop keeps grant; req=0 -> grant falls 1 cycle later.
REQ-047 rst pulsed mid-STREAM -> all outputs 0 immediately (asynchronously); start ignored until rst=0.

Source files
------------

// File: rtl/ccsds_cmprs_ctrl_if.sv
// ---------------------------------------------------------------------------
// ccsds_cmprs_ctrl_if
// Bundles the frame-control, source-stream, compressor and DDR-grant signals
// of the compressor controller.
//   master : environment side (drives start/abort/config, source beats,
//            compressor handshakes)
//   slave  : controller side (ccsds_cmprs_ctrl)
// Signals:
//   start, abort, cfg_x_max, cfg_z_max, cfg_mode, cfg_lines  - frame control
//   src_valid, src_ready, src_data[23:0]                     - source beats
//   X_max, Z_max, mode, cfg_en                                - compressor cfg
//   cmprs_rdf_data_ready/valid, cmprs_rdf_rd_data, _data_end  - compressor feed
//   cmprs_dout_req, ddr_wr_rdy, cmprs_fifo_grant, cmprs_dout_end
//   busy, done, cfg_err                                       - status
// ---------------------------------------------------------------------------
interface ccsds_cmprs_ctrl_if #(
    parameter int X_LEN = 11,
    parameter int Z_LEN = 8,
    parameter int L_LEN = 16
);
    logic             start;
    logic             abort;
    logic [X_LEN-1:0] cfg_x_max;
    logic [Z_LEN-1:0] cfg_z_max;
    logic [1:0]       cfg_mode;
    logic [L_LEN-1:0] cfg_lines;

    logic             src_valid;
    logic             src_ready;
    logic [23:0]      src_data;

    logic [X_LEN-1:0] X_max;
    logic [Z_LEN-1:0] Z_max;
    logic [1:0]       mode;
    logic             cfg_en;

    logic             cmprs_rdf_data_ready;
    logic             cmprs_rdf_data_valid;
    logic [31:0]      cmprs_rdf_rd_data;
    logic             cmprs_rdf_data_end;

    logic             cmprs_dout_req;
    logic             ddr_wr_rdy;
    logic             cmprs_fifo_grant;
    logic             cmprs_dout_end;

    logic             busy;
    logic             done;
    logic             cfg_err;

    modport master (
        output start, abort, cfg_x_max, cfg_z_max, cfg_mode, cfg_lines,
        output src_valid, src_data,
        output cmprs_rdf_data_ready, cmprs_dout_req, ddr_wr_rdy, cmprs_dout_end,
        input  src_ready, X_max, Z_max, mode, cfg_en,
        input  cmprs_rdf_data_valid, cmprs_rdf_rd_data, cmprs_rdf_data_end,
        input  cmprs_fifo_grant, busy, done, cfg_err
    );

    modport slave (
        input  start, abort, cfg_x_max, cfg_z_max, cfg_mode, cfg_lines,
        input  src_valid, src_data,
        input  cmprs_rdf_data_ready, cmprs_dout_req, ddr_wr_rdy, cmprs_dout_end,
        output src_ready, X_max, Z_max, mode, cfg_en,
        output cmprs_rdf_data_valid, cmprs_rdf_rd_data, cmprs_rdf_data_end,
        output cmprs_fifo_grant, busy, done, cfg_err
    );
endinterface

// File: rtl/ccsds_cmprs_ctrl.sv
// ---------------------------------------------------------------------------
// ccsds_cmprs_ctrl
// Frame controller feeding a CCSDS compressor. A start pulse latches the frame
// configuration, strobes it into the compressor, then streams
// (X_max+1)*(Z_max+1)*lines source beats into the compressor read port,
// unpacking each 24-bit beat {high,low} into {4'd0,high,4'd0,low}. After the
// last beat it waits for the compressor flush, pulses done and returns to
// idle. The DDR write-port grant is tracked independently of the frame FSM.
// Ports:
//   sclk : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ccsds_cmprs_ctrl_if.slave (all control, data and status signals)
// ---------------------------------------------------------------------------
module ccsds_cmprs_ctrl #(
    parameter int X_LEN = 11,
    parameter int Z_LEN = 8,
    parameter int L_LEN = 16
) (
    input logic                sclk,
    input logic                rst,
    ccsds_cmprs_ctrl_if.slave  bus
);
    localparam int B_LEN = X_LEN + Z_LEN;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CFG    = 3'd1,
        S_WAIT   = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           r_state;
    logic [X_LEN-1:0] r_x_max;
    logic [Z_LEN-1:0] r_z_max;
    logic [1:0]       r_mode;
    logic [B_LEN-1:0] r_beat_last;   // index of the last beat in a line
    logic [L_LEN-1:0] r_line_last;   // index of the last line in the frame
    logic [B_LEN-1:0] r_beat;
    logic [L_LEN-1:0] r_line;
    logic             r_cfg_en;
    logic             r_busy;
    logic             r_done;
    logic             r_cfg_err;

    logic             r_valid;
    logic [31:0]      r_data;
    logic             r_end;
    logic             r_grant;

    logic [B_LEN-1:0] w_beat_last_calc;
    logic             w_src_ready;
    logic             w_xfer;
    logic             w_last_beat;
    logic             w_last_line;

    // (x+1)*(z+1)-1 = x*z + x + z; its maximum (2^B_LEN - 1) fits exactly in
    // B_LEN bits, so storing the last index avoids the extra bit the beat
    // count itself would need.
    assign w_beat_last_calc = B_LEN'(bus.cfg_x_max) * B_LEN'(bus.cfg_z_max)
                            + B_LEN'(bus.cfg_x_max) + B_LEN'(bus.cfg_z_max);

    // Leaving STREAM on the final transfer makes "beats remain" equal to
    // being in STREAM. abort gates ready so no beat slips out on that cycle.
    assign w_src_ready = (r_state == S_STREAM) && bus.cmprs_rdf_data_ready && !bus.abort;
    assign w_xfer      = bus.src_valid && w_src_ready;
    assign w_last_beat = (r_beat == r_beat_last);
    assign w_last_line = (r_line == r_line_last);

    // Frame FSM with counters and registered strobes.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_x_max     <= '0;
            r_z_max     <= '0;
            r_mode      <= '0;
            r_beat_last <= '0;
            r_line_last <= '0;
            r_beat      <= '0;
            r_line      <= '0;
            r_cfg_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else if (bus.abort) begin
            r_state     <= S_IDLE;
            r_x_max     <= '0;
            r_z_max     <= '0;
            r_mode      <= '0;
            r_beat      <= '0;
            r_line      <= '0;
            r_cfg_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.cfg_lines != '0) begin
                            r_x_max     <= bus.cfg_x_max;
                            r_z_max     <= bus.cfg_z_max;
                            r_mode      <= bus.cfg_mode;
                            r_beat_last <= w_beat_last_calc;
                            r_line_last <= bus.cfg_lines - L_LEN'(1);
                            r_beat      <= '0;
                            r_line      <= '0;
                            r_cfg_err   <= 1'b0;
                            r_cfg_en    <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= S_CFG;
                        end else begin
                            r_cfg_err   <= 1'b1;
                        end
                    end
                end
                S_CFG: begin
                    r_cfg_en <= 1'b0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.cmprs_rdf_data_ready) begin
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_xfer) begin
                        if (w_last_beat) begin
                            r_beat <= '0;
                            if (w_last_line) begin
                                r_line  <= '0;
                                r_state <= S_DRAIN;
                            end else begin
                                r_line <= r_line + L_LEN'(1);
                            end
                        end else begin
                            r_beat <= r_beat + B_LEN'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.cmprs_dout_end) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_cfg_en <= 1'b0;
                    r_done   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    // Output beat register: one-cycle latency from the source handshake.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_end   <= 1'b0;
        end else if (bus.abort) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_end   <= 1'b0;
        end else begin
            r_valid <= w_xfer;
            r_end   <= w_xfer && w_last_beat && w_last_line;
            if (w_xfer) begin
                r_data <= {4'd0, bus.src_data[23:12], 4'd0, bus.src_data[11:0]};
            end
        end
    end

    // DDR grant: needs ddr_wr_rdy only to be acquired; once held it follows
    // cmprs_dout_req alone.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_grant <= 1'b0;
        end else if (bus.abort) begin
            r_grant <= 1'b0;
        end else if (r_grant) begin
            r_grant <= bus.cmprs_dout_req;
        end else begin
            r_grant <= bus.cmprs_dout_req && bus.ddr_wr_rdy;
        end
    end

    assign bus.src_ready            = w_src_ready;
    assign bus.X_max                = r_x_max;
    assign bus.Z_max                = r_z_max;
    assign bus.mode                 = r_mode;
    assign bus.cfg_en               = r_cfg_en;
    assign bus.cmprs_rdf_data_valid = r_valid;
    assign bus.cmprs_rdf_rd_data    = r_data;
    assign bus.cmprs_rdf_data_end   = r_end;
    assign bus.cmprs_fifo_grant     = r_grant;
    assign bus.busy                 = r_busy;
    assign bus.done                 = r_done;
    assign bus.cfg_err              = r_cfg_err;
endmodule

// File: tb/tb_ccsds_cmprs_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ccsds_cmprs_ctrl
// Directed frames with a scoreboard: each frame's expected output beats are
// queued when the frame is launched; an independent monitor pops and compares
// every beat the controller presents. Control/status checks run inline.
// ---------------------------------------------------------------------------
module tb_ccsds_cmprs_ctrl;
    logic sclk = 1'b0;
    logic rst  = 1'b0;

    always #5 sclk = ~sclk;

    ccsds_cmprs_ctrl_if #(.X_LEN(11), .Z_LEN(8), .L_LEN(16)) bus ();

    ccsds_cmprs_ctrl #(.X_LEN(11), .Z_LEN(8), .L_LEN(16)) dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb_q[$];

    int m_pass  = 0;
    int m_total = 0;
    int c_pass  = 0;
    int c_total = 0;
    int n_cfg_en = 0;
    int n_done   = 0;

    // Source beat k carries high = 0x0A0+3k, low = 0x500+7k.
    function automatic logic [23:0] src_word(input int k);
        logic [11:0] hi;
        logic [11:0] lo;
        hi = 12'(32'h0A0 + k * 3);
        lo = 12'(32'h500 + k * 7);
        return {hi, lo};
    endfunction

    // Expected compressor word: 12-bit fields zero-padded into 16-bit halves.
    function automatic logic [31:0] exp_word(input int k);
        logic [31:0] hi32;
        logic [31:0] lo32;
        hi32 = (32'h0A0 + k * 3) & 32'hFFF;
        lo32 = (32'h500 + k * 7) & 32'hFFF;
        return (hi32 << 16) | lo32;
    endfunction

    function automatic logic [63:0] all_out();
        return 64'({bus.X_max, bus.Z_max, bus.mode, bus.cfg_en,
                    bus.cmprs_rdf_data_valid, bus.cmprs_rdf_rd_data,
                    bus.cmprs_rdf_data_end, bus.cmprs_fifo_grant,
                    bus.src_ready, bus.busy, bus.done, bus.cfg_err});
    endfunction

    // Monitor / scoreboard consumer.
    always @(negedge sclk) begin
        exp_t e;
        if (!rst) begin
            if (bus.cfg_en) n_cfg_en++;
            if (bus.done)   n_done++;
            if (bus.cmprs_rdf_data_valid) begin
                m_total++;
                if (sb_q.size() == 0) begin
                    $display("FAIL beat_unexpected: got data=%h end=%b, required no beat",
                             bus.cmprs_rdf_rd_data, bus.cmprs_rdf_data_end);
                end else begin
                    e = sb_q.pop_front();
                    if (bus.cmprs_rdf_rd_data === e.data && bus.cmprs_rdf_data_end === e.last) begin
                        m_pass++;
                        $display("beat data=%h end=%b ok", bus.cmprs_rdf_rd_data, bus.cmprs_rdf_data_end);
                    end else begin
                        $display("FAIL beat: got data=%h end=%b, required data=%h end=%b",
                                 bus.cmprs_rdf_rd_data, bus.cmprs_rdf_data_end, e.data, e.last);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        c_total++;
        if (act === exp) begin
            c_pass++;
            $display("check %s = %0h ok", name, act);
        end else begin
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic push_frame(input int n, input int total);
        for (int k = 0; k < n; k++) begin
            sb_q.push_back('{data: exp_word(k), last: (k == total - 1)});
        end
    endtask

    task automatic do_start(input int x, input int z, input int m, input int lines);
        bus.cfg_x_max = 11'(x);
        bus.cfg_z_max = 8'(z);
        bus.cfg_mode  = 2'(m);
        bus.cfg_lines = 16'(lines);
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    // Offers beats in order; returns early when beat index reaches stop_at.
    task automatic stream(input int total, input bit gaps, input int stop_at);
        int  k   = 0;
        int  cyc = 0;
        bit  w;
        while (k < total && cyc < 500) begin
            if (k == stop_at) break;
            bus.src_valid            = gaps ? (cyc % 2 == 0) : 1'b1;
            bus.src_data             = src_word(k);
            bus.cmprs_rdf_data_ready = gaps ? !(cyc >= 5 && cyc < 8) : 1'b1;
            @(negedge sclk);
            w = bus.src_valid && bus.src_ready;
            tick();
            if (w) k++;
            cyc++;
        end
        bus.src_valid = 1'b0;
        bus.cmprs_rdf_data_ready = 1'b1;
        if (stop_at < 0) check("beats_accepted", 64'(k), 64'(total));
    endtask

    task automatic wait_drained();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic finish_frame();
        int d0 = n_done;
        @(negedge sclk);
        check("drain_busy", 64'(bus.busy), 64'd1);
        check("drain_no_done", 64'(bus.done), 64'd0);
        tick();
        bus.cmprs_dout_end = 1'b1;
        @(negedge sclk);
        check("done_not_yet", 64'(bus.done), 64'd0);
        tick();
        bus.cmprs_dout_end = 1'b0;
        @(negedge sclk);
        check("done_pulse", 64'(bus.done), 64'd1);
        tick();
        @(negedge sclk);
        check("done_cleared", 64'(bus.done), 64'd0);
        check("idle_not_busy", 64'(bus.busy), 64'd0);
        check("done_cycles", 64'(n_done - d0), 64'd1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        bus.start = 0; bus.abort = 0;
        bus.cfg_x_max = 0; bus.cfg_z_max = 0; bus.cfg_mode = 0; bus.cfg_lines = 0;
        bus.src_valid = 0; bus.src_data = 0;
        bus.cmprs_rdf_data_ready = 0; bus.cmprs_dout_req = 0;
        bus.ddr_wr_rdy = 0; bus.cmprs_dout_end = 0;

        // Reset state
        #1 rst = 1'b1;
        #2 check("reset_outputs", all_out(), 64'd0);
        repeat (3) @(posedge sclk);
        #1 rst = 1'b0;
        @(negedge sclk);
        check("post_reset_outputs", all_out(), 64'd0);
        tick();

        // Frame 1: x=3 z=1 lines=2, continuous flow
        c0 = n_cfg_en;
        push_frame(16, 16);
        do_start(3, 1, 2, 2);
        stream(16, 1'b0, -1);
        wait_drained();
        check("cfg_en_cycles", 64'(n_cfg_en - c0), 64'd1);
        check("x_max_held", 64'(bus.X_max), 64'd3);
        check("z_max_held", 64'(bus.Z_max), 64'd1);
        check("mode_held", 64'(bus.mode), 64'd2);
        finish_frame();

        // Frame 2: gaps on src_valid, ready stall mid-line, stray dout_end
        c0 = n_done;
        push_frame(16, 16);
        do_start(3, 1, 1, 2);
        bus.cmprs_dout_end = 1'b1;
        stream(16, 1'b1, -1);
        bus.cmprs_dout_end = 1'b0;
        wait_drained();
        check("stray_dout_end_ignored", 64'(n_done - c0), 64'd0);
        finish_frame();

        // lines=0 -> cfg_err, then valid start clears it
        do_start(3, 1, 0, 0);
        @(negedge sclk);
        check("cfg_err_set", 64'(bus.cfg_err), 64'd1);
        check("cfg_err_not_busy", 64'(bus.busy), 64'd0);
        tick(); tick();
        @(negedge sclk);
        check("cfg_err_sticky", 64'(bus.cfg_err), 64'd1);
        check("cfg_err_still_idle", 64'(bus.busy), 64'd0);
        tick();
        push_frame(8, 8);
        do_start(3, 1, 0, 1);
        @(negedge sclk);
        check("cfg_err_cleared", 64'(bus.cfg_err), 64'd0);
        check("frame_busy", 64'(bus.busy), 64'd1);
        tick();
        stream(8, 1'b0, -1);
        wait_drained();
        finish_frame();

        // Abort at beat 5 with grant held
        bus.cmprs_dout_req = 1'b1;
        bus.ddr_wr_rdy     = 1'b1;
        push_frame(5, 16);
        do_start(3, 1, 0, 2);
        stream(16, 1'b0, 5);
        bus.src_valid = 1'b1;
        bus.src_data  = src_word(5);
        bus.abort     = 1'b1;
        @(negedge sclk);
        check("abort_src_ready", 64'(bus.src_ready), 64'd0);
        tick();
        bus.abort = 1'b0;
        bus.src_valid = 1'b0;
        bus.cmprs_dout_req = 1'b0;
        bus.ddr_wr_rdy = 1'b0;
        @(negedge sclk);
        check("abort_outputs", all_out(), 64'd0);
        tick();
        wait_drained();
        push_frame(4, 4);
        do_start(1, 1, 3, 1);
        stream(4, 1'b0, -1);
        wait_drained();
        finish_frame();

        // Grant handshake
        bus.cmprs_dout_req = 1'b1;
        bus.ddr_wr_rdy     = 1'b0;
        repeat (4) tick();
        @(negedge sclk);
        check("grant_wait_rdy", 64'(bus.cmprs_fifo_grant), 64'd0);
        tick();
        bus.ddr_wr_rdy = 1'b1;
        @(negedge sclk);
        check("grant_one_cycle_late", 64'(bus.cmprs_fifo_grant), 64'd0);
        tick();
        @(negedge sclk);
        check("grant_rise", 64'(bus.cmprs_fifo_grant), 64'd1);
        tick();
        bus.ddr_wr_rdy = 1'b0;
        tick();
        @(negedge sclk);
        check("grant_kept_rdy_drop", 64'(bus.cmprs_fifo_grant), 64'd1);
        tick();
        bus.cmprs_dout_req = 1'b0;
        @(negedge sclk);
        check("grant_fall_late", 64'(bus.cmprs_fifo_grant), 64'd1);
        tick();
        @(negedge sclk);
        check("grant_fall", 64'(bus.cmprs_fifo_grant), 64'd0);
        tick();

        // Reset mid-stream
        push_frame(4, 16);
        do_start(3, 1, 0, 2);
        stream(16, 1'b0, 5);
        rst = 1'b1;
        #1 check("async_reset_outputs", all_out(), 64'd0);
        bus.src_valid = 1'b0;
        tick();
        do_start(3, 1, 0, 1);
        tick();
        rst = 1'b0;
        @(negedge sclk);
        check("start_ignored_in_reset", 64'(bus.busy), 64'd0);
        check("reset_release_outputs", all_out(), 64'd0);
        tick(); tick();
        wait_drained();
        push_frame(4, 4);
        do_start(1, 1, 0, 1);
        stream(4, 1'b0, -1);
        wait_drained();
        finish_frame();

        $display("%0d/%0d checks passed", c_pass + m_pass, c_total + m_total);
        $finish;
    end
endmodule
